// File: rtl/step_ctrl_pkg.sv
// Shared types and default widths for the run/halt/single-step controller.
// STEP_CTRL_BREAKPOINT_EN adds the PC width default used by the breakpoint comparator.
package step_ctrl_pkg;

    localparam int DEF_STEP_W = 16;
    localparam int DEF_CNT_W  = 32;
`ifdef STEP_CTRL_BREAKPOINT_EN
    localparam int DEF_PC_W   = 32;
`endif

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_RUN  = 2'b01,
        OP_HALT = 2'b10,
        OP_STEP = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        S_HALTED   = 2'b00,
        S_RUNNING  = 2'b01,
        S_STEPPING = 2'b10
    } state_t;

    function automatic logic core_active(input state_t s);
        return (s != S_HALTED);
    endfunction

endpackage

// File: rtl/step_ctrl_if.sv
// Command handshake bundle: valid/ready with opcode and step count.
interface step_ctrl_if
    import step_ctrl_pkg::*;
#(
    parameter int STEP_W = DEF_STEP_W
);
    logic              CMD_VALID;
    logic              CMD_READY;
    cmd_op_t           CMD_OP;
    logic [STEP_W-1:0] CMD_STEPS;

    modport master (
        output CMD_VALID,
        output CMD_OP,
        output CMD_STEPS,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OP,
        input  CMD_STEPS,
        output CMD_READY
    );
endinterface

// File: rtl/step_ctrl_downcnt.sv
// Loadable down-counter tracking the cycles left in a STEP; flags the final cycle.
module step_ctrl_downcnt
    import step_ctrl_pkg::*;
#(
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              dec,
    input  logic              clr,
    input  logic [STEP_W-1:0] load_val,
    output logic              is_one
);

    logic [STEP_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == STEP_W'(1));

endmodule

// File: rtl/step_ctrl.sv
// Run/halt/single-step controller producing the registered core clock enable.
// STEP_CTRL_BREAKPOINT_EN adds a PC breakpoint that halts the core and sets sticky BP_HIT.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int STEP_W = DEF_STEP_W,
    parameter int CNT_W  = DEF_CNT_W
`ifdef STEP_CTRL_BREAKPOINT_EN
    ,
    parameter int PC_W   = DEF_PC_W
`endif
) (
    input  logic             CLOCK,
    input  logic             nRESET,
    step_ctrl_if.slave       cmd,
    input  logic             HALT_REQ,
    output logic             CORE_EN,
    output logic             HALTED,
    output logic             DONE,
    output logic [CNT_W-1:0] CYCLES
`ifdef STEP_CTRL_BREAKPOINT_EN
    ,
    input  logic             BP_ARM,
    input  logic [PC_W-1:0]  BP_ADDR,
    input  logic [PC_W-1:0]  CORE_PC,
    output logic             BP_HIT
`endif
);

    state_t state, state_nxt;
    logic   done_nxt;
    logic   accept;
    logic   step_zero;
    logic   bp_now;
    logic   halt_evt;
    logic   cnt_load, cnt_dec, cnt_clr, cnt_is_one;

    assign cmd.CMD_READY = (state != S_STEPPING);
    assign accept        = cmd.CMD_VALID & cmd.CMD_READY;
    assign step_zero     = (cmd.CMD_STEPS == '0);
    assign HALTED        = (state == S_HALTED);

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bp_now = BP_ARM & (CORE_PC == BP_ADDR) & core_active(state);
`else
    assign bp_now = 1'b0;
`endif

    // Core-side halt sources outrank any command presented in the same cycle.
    assign halt_evt = HALT_REQ | bp_now;

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            state   <= S_HALTED;
            CORE_EN <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            CORE_EN <= core_active(state_nxt);
            DONE    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state)
            S_HALTED: begin
                if (accept) begin
                    unique case (cmd.CMD_OP)
                        OP_RUN:  state_nxt = S_RUNNING;
                        OP_HALT: done_nxt = 1'b1;
                        OP_STEP: begin
                            if (step_zero) begin
                                done_nxt = 1'b1;
                            end else begin
                                cnt_load  = 1'b1;
                                state_nxt = S_STEPPING;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUNNING: begin
                if (halt_evt) begin
                    state_nxt = S_HALTED;
                    done_nxt  = 1'b1;
                end else if (accept) begin
                    unique case (cmd.CMD_OP)
                        OP_HALT: begin
                            state_nxt = S_HALTED;
                            done_nxt  = 1'b1;
                        end
                        OP_STEP: begin
                            if (step_zero) begin
                                state_nxt = S_HALTED;
                                done_nxt  = 1'b1;
                            end else begin
                                cnt_load  = 1'b1;
                                state_nxt = S_STEPPING;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STEPPING: begin
                if (halt_evt) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_HALTED;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one) begin
                        state_nxt = S_HALTED;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = S_HALTED;
        endcase
    end

    step_ctrl_downcnt #(
        .STEP_W (STEP_W)
    ) u_downcnt (
        .clk      (CLOCK),
        .rst_n    (nRESET),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .load_val (cmd.CMD_STEPS),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            CYCLES <= '0;
        end else begin
            CYCLES <= CYCLES + CNT_W'(CORE_EN);
        end
    end

`ifdef STEP_CTRL_BREAKPOINT_EN
    // A hit in the same cycle as a RUN/STEP accept wins, so the flag stays set.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            BP_HIT <= 1'b0;
        end else if (bp_now) begin
            BP_HIT <= 1'b1;
        end else if (accept && (cmd.CMD_OP == OP_RUN || cmd.CMD_OP == OP_STEP)) begin
            BP_HIT <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: stimulus pushes expected DONE records, a monitor pops and checks them.
module tb_step_ctrl;
    import step_ctrl_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] cycles;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        nRESET;
    logic        HALT_REQ;
    logic        CORE_EN;
    logic        HALTED;
    logic        DONE;
    logic [31:0] CYCLES;
`ifdef STEP_CTRL_BREAKPOINT_EN
    logic        BP_ARM;
    logic [31:0] BP_ADDR;
    logic [31:0] CORE_PC;
    logic        BP_HIT;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    step_ctrl_if #(.STEP_W(16)) cmd_if ();

    step_ctrl #(
        .STEP_W (16),
        .CNT_W  (32)
    ) dut (
        .CLOCK    (CLOCK),
        .nRESET   (nRESET),
        .cmd      (cmd_if),
        .HALT_REQ (HALT_REQ),
        .CORE_EN  (CORE_EN),
        .HALTED   (HALTED),
        .DONE     (DONE),
        .CYCLES   (CYCLES)
`ifdef STEP_CTRL_BREAKPOINT_EN
        ,
        .BP_ARM   (BP_ARM),
        .BP_ADDR  (BP_ADDR),
        .CORE_PC  (CORE_PC),
        .BP_HIT   (BP_HIT)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic expect_done(input string name, input logic [31:0] cyc);
        exp_t e;
        e.name   = name;
        e.cycles = cyc;
        sb.push_back(e);
    endtask

    // Presents a command and returns just after the edge that accepts it.
    task automatic send(input cmd_op_t op, input logic [15:0] steps);
        int budget;
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = op;
        cmd_if.CMD_STEPS = steps;
        budget = 0;
        while (!cmd_if.CMD_READY && budget < 300) begin
            tick();
            budget++;
        end
        chk("ready_before_send", {63'd0, cmd_if.CMD_READY}, 64'd1);
        tick();
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = OP_NOP;
        cmd_if.CMD_STEPS = '0;
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (DONE === 1'b1) begin
                chk("done_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({e.name, "_cycles"}, {32'd0, CYCLES}, {32'd0, e.cycles});
                    chk({e.name, "_halted"}, {63'd0, HALTED}, 64'd1);
                    chk({e.name, "_core_en"}, {63'd0, CORE_EN}, 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nRESET           = 1'b0;
        HALT_REQ         = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = OP_NOP;
        cmd_if.CMD_STEPS = '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
        BP_ARM  = 1'b0;
        BP_ADDR = 32'h0;
        CORE_PC = 32'h0;
`endif
        repeat (3) tick();
        nRESET = 1'b1;
        repeat (5) tick();
        chk("rst_core_en", {63'd0, CORE_EN}, 64'd0);
        chk("rst_halted",  {63'd0, HALTED}, 64'd1);
        chk("rst_done",    {63'd0, DONE}, 64'd0);
        chk("rst_cycles",  {32'd0, CYCLES}, 64'd0);
        chk("rst_ready",   {63'd0, cmd_if.CMD_READY}, 64'd1);

        // NOP while halted: no state change and no DONE
        send(OP_NOP, 16'd7);
        tick();
        chk("nop_halted", {63'd0, HALTED}, 64'd1);
        chk("nop_core_en", {63'd0, CORE_EN}, 64'd0);

        // STEP 3: exactly three enabled cycles, then DONE
        expect_done("step3", 32'd3);
        send(OP_STEP, 16'd3);
        for (int i = 0; i < 3; i++) begin
            chk("step3_en", {63'd0, CORE_EN}, 64'd1);
            chk("step3_ready", {63'd0, cmd_if.CMD_READY}, 64'd0);
            chk("step3_nodone", {63'd0, DONE}, 64'd0);
            tick();
        end
        chk("step3_off", {63'd0, CORE_EN}, 64'd0);
        chk("step3_done", {63'd0, DONE}, 64'd1);
        chk("step3_total", {32'd0, CYCLES}, 64'd3);
        repeat (3) tick();

        // RUN, 10 idle cycles, HALT accepted on the 11th enabled edge
        send(OP_RUN, 16'd0);
        chk("run_en", {63'd0, CORE_EN}, 64'd1);
        repeat (10) tick();
        expect_done("run_halt", 32'd14);
        send(OP_HALT, 16'd0);
        chk("run_halt_off", {63'd0, CORE_EN}, 64'd0);
        chk("run_halt_cycles", {32'd0, CYCLES}, 64'd14);
        repeat (3) tick();

        // STEP 0 while halted: DONE only
        expect_done("step0", 32'd14);
        send(OP_STEP, 16'd0);
        repeat (3) tick();
        chk("step0_cycles", {32'd0, CYCLES}, 64'd14);

        // Back-to-back HALT then STEP 0 while halted: two consecutive DONEs
        expect_done("b2b_halt", 32'd14);
        expect_done("b2b_step0", 32'd14);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = OP_HALT;
        tick();
        cmd_if.CMD_OP    = OP_STEP;
        cmd_if.CMD_STEPS = '0;
        tick();
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = OP_NOP;
        repeat (3) tick();

        // HALT_REQ and STEP 5 together while running: halt wins, STEP dropped
        send(OP_RUN, 16'd0);
        expect_done("hreq_step", 32'd15);
        HALT_REQ         = 1'b1;
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = OP_STEP;
        cmd_if.CMD_STEPS = 16'd5;
        tick();
        HALT_REQ         = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = OP_NOP;
        cmd_if.CMD_STEPS = '0;
        chk("hreq_halted", {63'd0, HALTED}, 64'd1);
        repeat (4) tick();
        chk("hreq_dropped_en", {63'd0, CORE_EN}, 64'd0);
        chk("hreq_cycles", {32'd0, CYCLES}, 64'd15);

        // HALT_REQ while halted is ignored
        HALT_REQ = 1'b1;
        repeat (2) tick();
        HALT_REQ = 1'b0;
        chk("hreq_idle_halted", {63'd0, HALTED}, 64'd1);

        // STEP 100 cut short by HALT_REQ after 60 enabled cycles
        send(OP_STEP, 16'd100);
        repeat (59) tick();
        expect_done("hreq_step100", 32'd75);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        chk("step100_halted", {63'd0, HALTED}, 64'd1);
        chk("step100_cycles", {32'd0, CYCLES}, 64'd75);
        chk("step100_ready", {63'd0, cmd_if.CMD_READY}, 64'd1);
        repeat (3) tick();

        // Reset in the middle of STEP 8: no DONE, counter cleared
        send(OP_STEP, 16'd8);
        repeat (4) tick();
        chk("mid_cycles", {32'd0, CYCLES}, 64'd79);
        nRESET = 1'b0;
        tick();
        chk("mid_rst_en", {63'd0, CORE_EN}, 64'd0);
        chk("mid_rst_cycles", {32'd0, CYCLES}, 64'd0);
        chk("mid_rst_done", {63'd0, DONE}, 64'd0);
        nRESET = 1'b1;
        repeat (3) tick();
        chk("post_rst_done", {63'd0, DONE}, 64'd0);

        // STEP 2 after reset
        expect_done("step2", 32'd2);
        send(OP_STEP, 16'd2);
        chk("step2_en0", {63'd0, CORE_EN}, 64'd1);
        tick();
        chk("step2_en1", {63'd0, CORE_EN}, 64'd1);
        tick();
        chk("step2_off", {63'd0, CORE_EN}, 64'd0);
        repeat (3) tick();
        chk("step2_cycles", {32'd0, CYCLES}, 64'd2);

`ifdef STEP_CTRL_BREAKPOINT_EN
        // Breakpoint at 0x40 while running
        BP_ARM  = 1'b1;
        BP_ADDR = 32'h40;
        CORE_PC = 32'h38;
        expect_done("bp", 32'd5);
        send(OP_RUN, 16'd0);
        tick();
        CORE_PC = 32'h3C;
        tick();
        CORE_PC = 32'h40;
        tick();
        chk("bp_halted", {63'd0, HALTED}, 64'd1);
        chk("bp_hit", {63'd0, BP_HIT}, 64'd1);
        CORE_PC = 32'h0;
        repeat (2) tick();
        chk("bp_hit_sticky", {63'd0, BP_HIT}, 64'd1);
        send(OP_RUN, 16'd0);
        chk("bp_hit_clear", {63'd0, BP_HIT}, 64'd0);
        expect_done("bp_halt", 32'd6);
        send(OP_HALT, 16'd0);
        repeat (3) tick();
`endif

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
Run/halt/single-step controller for the processor core clock domain. Runs on the free-running testbench/board clock and produces CORE_EN. CORE_EN drives the core clock-enable and the ENABLE input of the gated clock generator. Accepts RUN/HALT/STEP commands over a valid/ready handshake, honours halt requests from the core, and counts enabled cycles for CPI measurement.

Parameters:
STEP_W, 16, width of step-count field
CNT_W, 32, width of enabled-cycle counter
PC_W, 32, width of PC compare (breakpoint feature only)

Ports:
CLOCK  input  1  free-running clock; all logic on posedge
nRESET  input  1  synchronous, active-low reset
CMD_VALID  input  1  command present
CMD_READY  output  1  command can be accepted
CMD_OP  input  2  00 NOP, 01 RUN, 10 HALT, 11 STEP
CMD_STEPS  input  STEP_W  cycle count for STEP
HALT_REQ  input  1  core halt request, level, sampled each cycle
CORE_EN  output  1  registered core clock enable
HALTED  output  1  1 when state is HALTED
DONE  output  1  one-cycle pulse on entry to HALTED
CYCLES  output  CNT_W  count of cycles with CORE_EN=1

Behaviour:
- Reset (nRESET=0 at posedge): state HALTED, CORE_EN=0, HALTED=1, DONE=0, CYCLES=0, remaining=0. Takes effect mid-run/mid-step with no DONE pulse.
- Accept = CMD_VALID & CMD_READY at posedge. CMD_READY = (state != STEPPING), combinational from state. NOP is accepted with no effect.
- States: HALTED, RUNNING, STEPPING. CORE_EN=1 iff state is RUNNING or STEPPING (registered with state).
- HALTED:
  - RUN -> RUNNING.
  - STEP n>0 -> STEPPING, remaining=n.
  - STEP n=0 -> stay HALTED, DONE pulse next cycle.
  - HALT -> stay HALTED, DONE pulse.
  - HALT_REQ is ignored.
- RUNNING:
  - HALT command or HALT_REQ -> HALTED, DONE.
  - STEP n>0 -> STEPPING, remaining=n.
  - STEP n=0 -> HALTED, DONE.
  - RUN -> no-op.
- STEPPING:
  - Each cycle, remaining decrements.
  - When remaining==1 -> HALTED, DONE.
  - HALT_REQ -> HALTED, DONE, remaining cleared.
- Latency: STEP n accepted at edge k -> CORE_EN=1 for cycles k+1..k+n exactly. CORE_EN=0 and DONE=1 in cycle k+n+1. RUN accepted at edge k -> CORE_EN=1 from cycle k+1. HALT accepted at edge k -> CORE_EN=0 from cycle k+1.
- Simultaneous events: HALT_REQ beats any command in the same cycle. The command is still consumed and dropped. Only one DONE pulse is generated.
- DONE never asserts two consecutive cycles, except for back-to-back HALT/STEP-0 commands issued while HALTED.
- CYCLES: increments each cycle CORE_EN=1 and wraps at 2^CNT_W. Not cleared by commands, only by reset.

Optional Feature:
- Macro: STEP_CTRL_BREAKPOINT_EN.
- When defined, adds ports:
  - BP_ARM input 1
  - BP_ADDR input PC_W
  - CORE_PC input PC_W
  - BP_HIT output 1
- In RUNNING or STEPPING, if BP_ARM & (CORE_PC==BP_ADDR) -> HALTED next edge, DONE pulse, BP_HIT set (sticky). BP_HIT has the same priority as HALT_REQ.
- BP_HIT clears on the next accepted RUN or STEP and on reset.
- When not defined: these ports and all breakpoint logic are absent; behaviour is otherwise identical.

Decomposition:
- Package step_ctrl_pkg:
  - cmd_op_t enum (OP_NOP, OP_RUN, OP_HALT, OP_STEP)
  - state_t enum (S_HALTED, S_RUNNING, S_STEPPING)
  - default width localparams
- One sub-module, step_ctrl_downcnt: loadable STEP_W down-counter with load, dec and is_one outputs. The FSM and CYCLES counter stay in step_ctrl.

Test Plan:
- Reset then idle 5 cycles -> CORE_EN=0, HALTED=1, DONE=0, CYCLES=0, CMD_READY=1.
- STEP 3 at edge k -> CORE_EN=1 exactly cycles k+1..k+3; DONE=1 only at k+4; CYCLES=3; CMD_READY=0 during k+1..k+3.
- RUN, wait 10, HALT -> CYCLES=11 (includes HALT-accept cycle), single DONE pulse, HALTED=1. Then STEP 0 -> DONE pulse, CYCLES unchanged.
- RUN, then HALT_REQ and STEP 5 in same cycle -> HALTED next cycle, one DONE, STEP dropped (CORE_EN stays 0). Also HALT_REQ during STEP 100 at remaining=40 -> halt next edge, CYCLES=60.
- nRESET=0 mid STEP 8 (after 4 enabled cycles) -> next edge CORE_EN=0, CYCLES=0, no DONE. nRESET held high -> STEP 2 works normally.
- With STEP_CTRL_BREAKPOINT_EN: BP_ARM=1, BP_ADDR=0x40, RUN, CORE_PC steps 0x38,0x3C,0x40 -> HALTED after the 0x40 cycle, BP_HIT=1; next RUN clears BP_HIT.
